// File: rtl/lzrw1_pkg.sv
// Shared types and copy-item decoding for the LZRW1 decompressor.
package lzrw1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LIT,
    COPY
  } state_t;

  localparam int LEN_W        = 4;
  localparam int OFFSET_W     = 12;
  localparam int MIN_COPY_LEN = 3;
  localparam int MAX_COPY_LEN = 16;

  typedef struct packed {
    logic [LEN_W:0]      len;
    logic [OFFSET_W-1:0] offset;
  } copy_item_t;

  // Copy item layout: {offset[11:8], len-1, offset[7:0]}.
  function automatic copy_item_t decode_copy(input logic [15:0] item);
    copy_item_t d;
    d.len    = {1'b0, item[11:8]} + (LEN_W+1)'(1);
    d.offset = {item[15:12], item[7:0]};
    return d;
  endfunction

endpackage

// File: rtl/lzrw1_history_buf.sv
// Circular output history: single write port, combinational read port, cleared on reset.
module lzrw1_history_buf #(
  parameter  int HISTORY_SIZE = 256,
  localparam int AW           = $clog2(HISTORY_SIZE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [HISTORY_SIZE];

  // NOTE: every entry is cleared on reset because copies that reach unwritten
  // history must read zeros; this forces a flop array rather than a RAM macro.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < HISTORY_SIZE; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lzrw1_decompressor_top.sv
// LZRW1 decompressor: one literal or copy item per handshake, one output byte per cycle.
module lzrw1_decompressor_top
  import lzrw1_pkg::*;
#(
  parameter int HISTORY_SIZE = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        control_word_in,
  input  logic        data_in_valid,
  output logic [7:0]  decompressed_byte,
  output logic        out_valid,
  output logic        decompressor_busy
);

  localparam int AW = $clog2(HISTORY_SIZE);

  state_t           r_state;
  state_t           w_next_state;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_src;
  logic [LEN_W-1:0] r_cnt;
  logic [7:0]       r_lit;
  logic [7:0]       r_out_byte;
  logic             r_out_valid;

  copy_item_t       w_item;
  logic [LEN_W:0]   w_len_m1;
  logic             w_accept;
  logic             w_emit;
  logic [7:0]       w_rdata;
  logic [7:0]       w_wdata;

  assign w_item   = decode_copy(data_in);
  assign w_len_m1 = w_item.len - (LEN_W+1)'(1);
  assign w_accept = (r_state == IDLE) && data_in_valid;
  assign w_emit   = (r_state == LIT) || (r_state == COPY);
  assign w_wdata  = (r_state == LIT) ? r_lit : w_rdata;

  lzrw1_history_buf #(
    .HISTORY_SIZE(HISTORY_SIZE)
  ) u_hist (
    .clock  (clock),
    .reset  (reset),
    .i_we   (w_emit),
    .i_waddr(r_wp),
    .i_wdata(w_wdata),
    .i_raddr(r_src),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the default assignment first means every path assigns w_next_state,
  // so no latch is inferred; combinational blocks use blocking '='.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (data_in_valid) w_next_state = control_word_in ? COPY : LIT;
      LIT:     w_next_state = IDLE;
      COPY:    if (r_cnt == '0) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // from the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wp        <= '0;
      r_src       <= '0;
      r_cnt       <= '0;
      r_lit       <= '0;
      r_out_byte  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_byte <= w_wdata;
        r_wp       <= r_wp + AW'(1);
      end
      if (w_accept) begin
        r_lit <= data_in[7:0];
        r_cnt <= w_len_m1[LEN_W-1:0];
        // Offset bits above the history width are deliberately discarded.
        r_src <= r_wp - w_item.offset[AW-1:0];
      end else if (r_state == COPY) begin
        r_src <= r_src + AW'(1);
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

  assign decompressed_byte = r_out_byte;
  assign out_valid         = r_out_valid;
  assign decompressor_busy = (r_state != IDLE);

endmodule

// File: tb/tb_lzrw1_decompressor_top.sv
// Directed self-checking bench for lzrw1_decompressor_top.
module tb_lzrw1_decompressor_top;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_in = '0;
  logic        control_word_in = 1'b0;
  logic        data_in_valid = 1'b0;
  logic [7:0]  decompressed_byte;
  logic        out_valid;
  logic        decompressor_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         busy_cycles;

  lzrw1_decompressor_top #(.HISTORY_SIZE(256)) dut (
    .clock            (clock),
    .reset            (reset),
    .data_in          (data_in),
    .control_word_in  (control_word_in),
    .data_in_valid    (data_in_valid),
    .decompressed_byte(decompressed_byte),
    .out_valid        (out_valid),
    .decompressor_busy(decompressor_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7) + 3);
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    data_in = '0;
    control_word_in = 1'b0;
    data_in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Presents one item, then samples every edge until busy falls, capturing
  // emitted bytes. With noise set, inputs are scrambled while busy.
  task automatic send(input logic cw, input logic [15:0] data, input bit noise);
    int n;
    @(negedge clock);
    data_in = data;
    control_word_in = cw;
    data_in_valid = 1'b1;
    @(posedge clock);
    #1;
    data_in_valid = 1'b0;
    busy_cycles = 0;
    n = 0;
    while (decompressor_busy && n < 40) begin
      busy_cycles++;
      if (noise) begin
        data_in = 16'($urandom);
        control_word_in = 1'($urandom);
        data_in_valid = 1'b1;
      end
      @(posedge clock);
      #1;
      if (out_valid) got_q.push_back(decompressed_byte);
      n++;
    end
    data_in_valid = 1'b0;
    if (decompressor_busy) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int emitted;
    bit stray;

    // Reset state and single literal with exact cycle timing.
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", decompressor_busy, 0);
    check("rst_byte", decompressed_byte, 0);
    check("rst_wp", dut.r_wp, 0);
    @(negedge clock);
    data_in = 16'h0041;
    control_word_in = 1'b0;
    data_in_valid = 1'b1;
    @(posedge clock);
    #1;
    data_in_valid = 1'b0;
    check("lit_busy_k", decompressor_busy, 1);
    check("lit_valid_k", out_valid, 0);
    @(posedge clock);
    #1;
    check("lit_valid_k1", out_valid, 1);
    check("lit_byte_k1", decompressed_byte, 8'h41);
    check("lit_busy_k1", decompressor_busy, 0);
    check("lit_wp", dut.r_wp, 1);
    @(posedge clock);
    #1;
    check("lit_valid_k2", out_valid, 0);
    check("lit_hold_k2", decompressed_byte, 8'h41);

    // Offset 0 after reset reads cleared history.
    do_reset();
    send(1'b1, 16'h0200, 1'b0);
    exp_q = '{8'h00, 8'h00, 8'h00};
    compare_q("off0");

    // Non-overlapping copy: "abc" + copy(len 3, offset 3).
    do_reset();
    send(1'b0, 16'h0061, 1'b0);
    send(1'b0, 16'h0062, 1'b0);
    send(1'b0, 16'h0063, 1'b0);
    send(1'b1, 16'h0203, 1'b0);
    check("abc_busy_cycles", busy_cycles, 3);
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
    compare_q("abcabc");

    // Overlapping copy: "x" + copy(len 4, offset 1).
    do_reset();
    send(1'b0, 16'h0078, 1'b0);
    check("x_busy_cycles", busy_cycles, 1);
    send(1'b1, 16'h0301, 1'b0);
    check("xx_busy_cycles", busy_cycles, 4);
    exp_q = '{8'h78, 8'h78, 8'h78, 8'h78, 8'h78};
    compare_q("xxxxx");

    // Max length and pointer wrap.
    do_reset();
    for (int i = 0; i < 250; i++) send(1'b0, {8'h00, pat(i)}, 1'b0);
    got_q.delete();
    send(1'b1, 16'h0F10, 1'b0);
    check("max_busy_cycles", busy_cycles, 16);
    for (int j = 0; j < 16; j++) exp_q.push_back(pat(234 + j));
    compare_q("max16");
    check("wrap_wp", dut.r_wp, 10);
    // Source 250..255 then 0..1: read crosses the end of the array.
    send(1'b1, 16'h0710, 1'b0);
    for (int j = 0; j < 8; j++) exp_q.push_back(pat(234 + j));
    compare_q("src_wrap");
    // wp = 18, offset 200 -> source 74.
    send(1'b1, 16'h0FC8, 1'b0);
    for (int j = 0; j < 16; j++) exp_q.push_back(pat(74 + j));
    compare_q("off200");

    // Busy masking: scrambled inputs during a len-16 copy.
    do_reset();
    for (int i = 0; i < 16; i++) send(1'b0, {8'h00, pat(i)}, 1'b0);
    got_q.delete();
    send(1'b1, 16'h0F10, 1'b1);
    check("mask_busy_cycles", busy_cycles, 16);
    for (int j = 0; j < 16; j++) exp_q.push_back(pat(j));
    compare_q("mask16");
    send(1'b0, 16'h0077, 1'b0);
    check("mask_next_busy", busy_cycles, 1);
    exp_q = '{8'h77};
    compare_q("mask_next");

    // Reset at the 5th byte of a len-10 copy.
    do_reset();
    for (int i = 0; i < 10; i++) send(1'b0, {8'h00, pat(i)}, 1'b0);
    got_q.delete();
    @(negedge clock);
    data_in = 16'h090A;
    control_word_in = 1'b1;
    data_in_valid = 1'b1;
    @(posedge clock);
    #1;
    data_in_valid = 1'b0;
    emitted = 0;
    for (int n = 0; n < 20 && emitted < 5; n++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        check($sformatf("abort_byte[%0d]", emitted), decompressed_byte, pat(emitted));
        emitted++;
      end
    end
    check("abort_reached5", emitted, 5);
    reset = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", decompressor_busy, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    stray = 1'b0;
    repeat (4) begin
      @(posedge clock);
      #1;
      if (out_valid || decompressor_busy) stray = 1'b1;
    end
    check("abort_quiet", stray, 0);
    send(1'b0, 16'h0055, 1'b0);
    exp_q = '{8'h55};
    compare_q("post_abort");
    check("post_abort_wp", dut.r_wp, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lzrw1_decompressor_top.md
Name: lzrw1_decompressor_top

Overview:
LZRW1 decompression engine. Accepts one compressed item per handshake (a literal byte or a 2-byte copy item, selected by its control-word bit). Emits decompressed bytes one per cycle while keeping a circular history of recent output. It sits behind the compressed-stream parser, which unpacks control words into per-item bits, and feeds a byte-wide output sink.

Parameters:
HISTORY_SIZE, 256, depth in bytes of the output history buffer; must be a power of two, range 16..4096.

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
data_in  in  16  item payload: literal in [7:0] ([15:8] ignored); copy item as {byte0, byte1}
control_word_in  in  1  0 = literal item, 1 = copy item
data_in_valid  in  1  item present; sampled only when decompressor_busy = 0
decompressed_byte  out  8  output byte
out_valid  out  1  decompressed_byte valid this cycle
decompressor_busy  out  1  1 = item in progress, inputs ignored

Behaviour:
- Reset (reset = 0, async) sets state IDLE, out_valid = 0, decompressor_busy = 0, decompressed_byte = 0, write pointer wp = 0, and every history entry = 0.
- Copy decode: len = data_in[11:8] + 1, valid range 3..16. offset = {data_in[15:12], data_in[7:0]}, 12 bits.
- Source address = (wp - offset) mod HISTORY_SIZE, using the low clog2(HISTORY_SIZE) bits. Offset upper bits beyond that width are discarded.
- FSM states: IDLE, LIT, COPY.
- IDLE:
  - On an edge with data_in_valid = 1 and busy = 0, latch the item, set busy <= 1, and go to LIT (cw = 0) or COPY (cw = 1), latching len and source address.
  - data_in_valid = 0 keeps the FSM in IDLE.
- LIT: on the next edge, output the byte (out_valid <= 1), write it to history[wp], wp++, busy <= 0, and return to IDLE.
- COPY: on each edge, output history[src] with out_valid <= 1, write that byte to history[wp], then increment src and wp (mod HISTORY_SIZE) and decrement the remaining count.
  - On the edge emitting the last byte, busy <= 0 and the FSM returns to IDLE.
- Latency and throughput:
  - Item accepted at edge k emits byte i (0-based) at edge k+1+i.
  - decompressor_busy is high from edge k to edge k+len (len = 1 for a literal), so it falls on the same edge as the last out_valid.
  - Next acceptance is no earlier than edge k+len+1, giving a minimum of len+1 cycles per item.
- out_valid is deasserted on any edge that emits no byte. decompressed_byte holds its last value when out_valid = 0.
- Overlapping copies (offset < len) are supported. History is a register array with combinational read, so the byte written at edge n is readable at edge n+1. Example: offset 1 replicates the previous byte.
- Offset 0, or an offset reaching bytes not yet written since reset, reads the current array contents (zeros after reset). This is not an error.
- data_in / control_word_in / data_in_valid changes while busy = 1 have no effect on the item in progress.
- Reset asserted mid-item aborts the item immediately; no further out_valid until a new item is accepted.
- wp wraps at HISTORY_SIZE with no stall.

Decomposition:
- Package lzrw1_pkg:
  - state enum {IDLE, LIT, COPY}
  - constants LEN_W = 4, OFFSET_W = 12, MIN_COPY_LEN = 3, MAX_COPY_LEN = 16
  - a copy-item decode function returning (len, offset)
- Sub-module lzrw1_history_buf: HISTORY_SIZE x 8 register array, one write port, one async read port, async active-low clear.
- FSM, pointers and counters stay in the top.

Test Plan:
- Literal: reset, then data_in = 0x0041, cw = 0, valid = 1 -> at edge k+1 out_valid = 1 with byte 0x41; busy high exactly one cycle; wp = 1.
- Non-overlapping copy: literals 'a', 'b', 'c', then cw = 1, data_in = 0x0203 (len 3, offset 3) -> outputs "abcabc" with one out_valid per byte; busy high 3 cycles for the copy item.
- Overlapping copy: literal 'x', then data_in = 0x0301 (len 4, offset 1) -> "xxxxx".
- Max length and wrap-around:
  - Feed 250 literals, then copy data_in = 0x0F10 (len 16, offset 16) -> 16 bytes equal to those 16 back; wp wraps past 255 correctly.
  - Then copy with offset = 200 across the wrap point -> correct bytes.
- Busy masking: during a len-16 copy, toggle data_in and control_word_in -> output sequence unchanged; the new item is accepted only after busy falls.
- Reset mid-copy: assert reset at the 5th byte of a len-10 copy -> out_valid and busy go to 0 immediately. Then literal 0x0055 -> output 0x55 and wp = 1.
